// File: rtl/rss_bus_arbiter_pkg.sv
// rss_bus_arbiter_pkg: shared widths and slot record for the rss bus arbiter
package rss_bus_arbiter_pkg;
  localparam int ID_W = 4;
  localparam int XLEN = 32;
  typedef struct packed {
    logic            full;
    logic [ID_W-1:0] dest;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] next_pc;
  } slot_t;
endpackage

// File: rtl/rss_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first.
// Ports: req (candidates), ptr (last winner; search starts at ptr+1),
//        grant (one-hot winner), idx (winner index), any (some candidate present).
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                          = 1'b1;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                idx                          = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/rss_bus_arbiter.sv
// rss_bus_arbiter: round-robin sequencer for the single rss result bus.
// Ports: clk, rst (async active-low), rdy (global stall), req_valid/req_ready
//        handshake with packed req_dest/req_value/req_next_pc per unit,
//        reset_from_rob_bus (flush), registered bus outputs dest/value/next_pc,
//        pending_count (occupied slots).
module rss_bus_arbiter
    import rss_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ID_W-1:0]       req_dest,
    input  logic [NUM_REQ*XLEN-1:0]       req_value,
    input  logic [NUM_REQ*XLEN-1:0]       req_next_pc,
    input  logic                          reset_from_rob_bus,
    output logic [ID_W-1:0]               dest_to_rss_bus,
    output logic [XLEN-1:0]               value_to_rss_bus,
    output logic [XLEN-1:0]               next_pc_to_rss_bus,
    output logic [$clog2(NUM_REQ+1)-1:0]  pending_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(NUM_REQ+1);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ-1);

    slot_t                slot [NUM_REQ];
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        idx;
    logic [NUM_REQ-1:0]   full;
    logic [NUM_REQ-1:0]   grant;
    logic                 any;
    logic                 accept_ok;

    always_comb begin
        full          = '0;
        pending_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i]       = slot[i].full;
            pending_count = pending_count + PW'(slot[i].full);
        end
    end

    // A granted slot frees on the same edge, so it may be refilled back-to-back.
    assign accept_ok = rst && !reset_from_rob_bus && rdy;
    assign req_ready = {NUM_REQ{accept_ok}} & (~full | grant);

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req   (full),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
            ptr                <= PTR_RST;
            dest_to_rss_bus    <= '0;
            value_to_rss_bus   <= '0;
            next_pc_to_rss_bus <= '0;
        end else if (reset_from_rob_bus) begin
            for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
            ptr                <= PTR_RST;
            dest_to_rss_bus    <= '0;
            value_to_rss_bus   <= '0;
            next_pc_to_rss_bus <= '0;
        end else if (rdy) begin
            dest_to_rss_bus    <= any ? slot[idx].dest    : '0;
            value_to_rss_bus   <= any ? slot[idx].value   : '0;
            next_pc_to_rss_bus <= any ? slot[idx].next_pc : '0;
            if (any) ptr <= idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                // dest 0 is accepted but leaves the slot empty
                if (req_valid[i] && req_ready[i])
                    slot[i] <= '{full:    req_dest[i*ID_W +: ID_W] != '0,
                                 dest:    req_dest[i*ID_W +: ID_W],
                                 value:   req_value[i*XLEN +: XLEN],
                                 next_pc: req_next_pc[i*XLEN +: XLEN]};
                else if (grant[i])
                    slot[i].full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rss_bus_arbiter.sv
// tb_rss_bus_arbiter: table vectors, hand sequences and random traffic against a reference model.
module tb_rss_bus_arbiter;
    import rss_bus_arbiter_pkg::*;
    localparam int NR = 3;
    localparam int PW = $clog2(NR+1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rdy = 1'b1;
    logic                 flush = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_ready;
    logic [NR*ID_W-1:0]   req_dest = '0;
    logic [NR*XLEN-1:0]   req_value = '0;
    logic [NR*XLEN-1:0]   req_next_pc = '0;
    logic [ID_W-1:0]      dest_to_rss_bus;
    logic [XLEN-1:0]      value_to_rss_bus;
    logic [XLEN-1:0]      next_pc_to_rss_bus;
    logic [PW-1:0]        pending_count;

    always #5 clk = ~clk;

    rss_bus_arbiter #(.NUM_REQ(NR)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_dest           (req_dest),
        .req_value          (req_value),
        .req_next_pc        (req_next_pc),
        .reset_from_rob_bus (flush),
        .dest_to_rss_bus    (dest_to_rss_bus),
        .value_to_rss_bus   (value_to_rss_bus),
        .next_pc_to_rss_bus (next_pc_to_rss_bus),
        .pending_count      (pending_count)
    );

    int errors = 0;
    int checks = 0;

    logic [NR-1:0]   m_full;
    logic [ID_W-1:0] m_dest [NR];
    logic [XLEN-1:0] m_val  [NR];
    logic [XLEN-1:0] m_npc  [NR];
    int              m_ptr;
    logic [ID_W-1:0] e_dest;
    logic [XLEN-1:0] e_val, e_npc;

    typedef struct {
        logic [NR-1:0]   v;
        logic [ID_W-1:0] d0;
        logic [ID_W-1:0] d1;
        logic            rd;
        logic            fl;
        logic [ID_W-1:0] exp;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_full = '0;
        m_ptr  = NR-1;
        e_dest = '0;
        e_val  = '0;
        e_npc  = '0;
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic [ID_W-1:0] d0, input logic [ID_W-1:0] d1,
                         input logic [ID_W-1:0] d2);
        logic [ID_W-1:0] d [NR];
        d = '{d0, d1, d2};
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_dest[i*ID_W +: ID_W]    = d[i];
            req_value[i*XLEN +: XLEN]   = 32'h0e + XLEN'(d[i]) + XLEN'(i << 12);
            req_next_pc[i*XLEN +: XLEN] = 32'hf8 + XLEN'(4 * int'(d[i]));
        end
    endtask

    // Starts at posedge+1; checks handshake mid-cycle, then bus after the edge.
    task automatic tick();
        int w;
        int cnt;
        logic [NR-1:0] er;
        w   = -1;
        cnt = 0;
        for (int k = 1; k <= NR; k++)
            if (w < 0 && m_full[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        for (int i = 0; i < NR; i++) begin
            er[i] = !flush && rdy && (!m_full[i] || i == w);
            cnt   = cnt + int'(m_full[i]);
        end
        #4;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("pending_count", 64'(pending_count), 64'(cnt));
        @(posedge clk);
        if (flush) model_clear();
        else if (rdy) begin
            if (w >= 0) begin
                e_dest    = m_dest[w];
                e_val     = m_val[w];
                e_npc     = m_npc[w];
                m_full[w] = 1'b0;
                m_ptr     = w;
            end else begin
                e_dest = '0;
                e_val  = '0;
                e_npc  = '0;
            end
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && er[i]) begin
                    m_full[i] = req_dest[i*ID_W +: ID_W] != '0;
                    m_dest[i] = req_dest[i*ID_W +: ID_W];
                    m_val[i]  = req_value[i*XLEN +: XLEN];
                    m_npc[i]  = req_next_pc[i*XLEN +: XLEN];
                end
        end
        #1;
        chk("bus_dest", 64'(dest_to_rss_bus), 64'(e_dest));
        chk("bus_value", 64'(value_to_rss_bus), 64'(e_val));
        chk("bus_next_pc", 64'(next_pc_to_rss_bus), 64'(e_npc));
    endtask

    initial begin
        // fairness: both units every cycle, unit 0 sends 1,2,3 and unit 1 sends 5,6,7
        tbl.push_back('{3'b011, 4'd1, 4'd5, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b011, 4'd2, 4'd6, 1'b1, 1'b0, 4'd1});
        tbl.push_back('{3'b011, 4'd3, 4'd6, 1'b1, 1'b0, 4'd5});
        tbl.push_back('{3'b011, 4'd3, 4'd7, 1'b1, 1'b0, 4'd2});
        tbl.push_back('{3'b010, 4'd0, 4'd7, 1'b1, 1'b0, 4'd6});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd3});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd7});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        // single request: dest 3 shows only after the second edge
        tbl.push_back('{3'b001, 4'd3, 4'd0, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd3});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        // zero dest is swallowed
        tbl.push_back('{3'b010, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        // flush drops 4 and 9, then grant restarts at unit 0
        tbl.push_back('{3'b011, 4'd4, 4'd9, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b011, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});
        // rdy stall holds dest 8, then dest 2 follows immediately
        tbl.push_back('{3'b001, 4'd8, 4'd0, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{3'b010, 4'd0, 4'd2, 1'b1, 1'b0, 4'd8});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0});

        model_clear();
        #12;
        chk("reset_dest", 64'(dest_to_rss_bus), 64'(0));
        chk("reset_value", 64'(value_to_rss_bus), 64'(0));
        chk("reset_next_pc", 64'(next_pc_to_rss_bus), 64'(0));
        chk("reset_ready", 64'(req_ready), 64'(0));
        chk("reset_pending", 64'(pending_count), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].d0, tbl[n].d1, 4'd0);
            rdy   = tbl[n].rd;
            flush = tbl[n].fl;
            tick();
            chk($sformatf("vec%0d_dest", n), 64'(dest_to_rss_bus), 64'(tbl[n].exp));
        end

        // asynchronous reset with two slots full and a result on the bus
        drive(3'b001, 4'd6, 4'd0, 4'd0);
        tick();
        drive(3'b011, 4'd4, 4'd5, 4'd0);
        tick();
        chk("pre_reset_dest", 64'(dest_to_rss_bus), 64'(6));
        chk("pre_reset_pending", 64'(pending_count), 64'(2));
        drive(3'b000, 4'd0, 4'd0, 4'd0);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_dest", 64'(dest_to_rss_bus), 64'(0));
        chk("async_reset_value", 64'(value_to_rss_bus), 64'(0));
        chk("async_reset_next_pc", 64'(next_pc_to_rss_bus), 64'(0));
        chk("async_reset_ready", 64'(req_ready), 64'(0));
        chk("async_reset_pending", 64'(pending_count), 64'(0));
        model_clear();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("post_reset_idle", 64'(dest_to_rss_bus), 64'(0));
        end

        // random traffic against the model
        for (int n = 0; n < 500; n++) begin
            drive(NR'($urandom), ID_W'($urandom), ID_W'($urandom), ID_W'($urandom));
            for (int i = 0; i < NR; i++) begin
                req_value[i*XLEN +: XLEN]   = $urandom;
                req_next_pc[i*XLEN +: XLEN] = $urandom;
            end
            rdy   = $urandom_range(0, 4) != 0;
            flush = $urandom_range(0, 15) == 0;
            tick();
        end
        rdy   = 1'b1;
        flush = 1'b0;
        drive('0, 4'd0, 4'd0, 4'd0);
        for (int n = 0; n < NR + 1; n++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
